// File: rtl/conv_layer_mem.sv
// conv_layer_mem
// Result memory for the CONV engine. It holds five banks, selected by csel or dump_sel:
//   001/010 : L0 kernel0/kernel1, L0_DEPTH words each
//   011/100 : L1 kernel0/kernel1, L1_DEPTH words each
//   101     : L2 flatten, L2_DEPTH words
// The bank arrays are never reset, so their contents survive a reset.
//
// Ports
//   clk, reset           : single rising-edge clock and an asynchronous active-high reset
//   cwr/caddr_wr/cdata_wr: CONV write port
//   crd/caddr_rd/cdata_rd: CONV read port. cdata_rd is registered and valid the cycle
//                          after crd. It holds its value while crd=0.
//   csel                 : bank select shared by the CONV read and write ports
//   dump_start/dump_sel  : request to stream one whole bank out
//   dump_valid/dump_ready: handshake for the streamed word (dump_addr, dump_data)
//   dump_done            : one-cycle pulse after the last word is accepted
//   err/err_clr          : sticky error flag. A new error has priority over err_clr.
module conv_layer_mem #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic [2:0]        csel,
  input  logic              dump_start,
  input  logic [2:0]        dump_sel,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              err,
  input  logic              err_clr
);

  localparam int NBANK = 5;
  localparam int DW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Returns the depth of the selected bank. It returns 0 for an unused code, so an
  // address check against this depth also rejects an invalid select.
  function automatic logic [DW-1:0] bank_depth(input logic [2:0] sel);
    logic [DW-1:0] d;
    d = '0;
    case (sel)
      3'b001, 3'b010: d = DW'(L0_DEPTH);
      3'b011, 3'b100: d = DW'(L1_DEPTH);
      3'b101:         d = DW'(L2_DEPTH);
      default:        d = '0;
    endcase
    return d;
  endfunction

  logic              wr_in, rd_in, dump_sel_ok, dump_last;
  logic              wr_hit, rd_hit, err_set;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;

  state_t            state_reg, state_next;
  logic [2:0]        dump_sel_reg, dump_sel_next;
  logic [ADDR_W-1:0] dump_addr_reg, dump_addr_next;
  logic              err_reg, err_next;
  // These two registers record which bank feeds each output register. The value 0
  // means "drive zero". This keeps the bank read registers free of reset.
  logic [2:0]        rd_src_reg;
  logic [2:0]        dump_src_reg;

  logic [DATA_W-1:0] conv_word [NBANK];
  logic [DATA_W-1:0] dump_word [NBANK];

  assign wr_in       = {1'b0, caddr_wr} < bank_depth(csel);
  assign rd_in       = {1'b0, caddr_rd} < bank_depth(csel);
  assign wr_hit      = cwr && wr_in;
  assign rd_hit      = crd && rd_in;
  assign dump_sel_ok = bank_depth(dump_sel) != '0;
  assign dump_last   = {1'b0, dump_addr_reg} == (bank_depth(dump_sel_reg) - 1'b1);

  // Each bank has one write port and two registered read ports: CONV and dump.
  // A read and a write to the same address on the same edge return the old word.
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    localparam logic [2:0] CODE  = 3'(gi + 1);
    localparam int         DEPTH = (gi < 2) ? L0_DEPTH : (gi < 4) ? L1_DEPTH : L2_DEPTH;
    localparam int         AW    = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] dump_q;

    always_ff @(posedge clk) begin
      if (wr_hit && csel == CODE)
        mem[caddr_wr[AW-1:0]] <= cdata_wr;
      if (rd_hit && csel == CODE)
        rd_q <= mem[caddr_rd[AW-1:0]];
      if (fetch_en && dump_sel_reg == CODE)
        dump_q <= mem[fetch_addr[AW-1:0]];
    end

    assign conv_word[gi] = rd_q;
    assign dump_word[gi] = dump_q;
  end

  // Dump FSM. LOAD fetches word 0. Each handshake in RUN fetches the next word on
  // the same edge, which gives one word per clock.
  always_comb begin
    state_next     = state_reg;
    dump_sel_next  = dump_sel_reg;
    dump_addr_next = dump_addr_reg;
    fetch_en       = 1'b0;
    fetch_addr     = dump_addr_reg;
    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          dump_sel_next  = dump_sel;
          dump_addr_next = '0;
          state_next     = dump_sel_ok ? LOAD : DONE;
        end
      end
      LOAD: begin
        fetch_en   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (dump_ready) begin
          if (dump_last) begin
            state_next = DONE;
          end else begin
            fetch_en       = 1'b1;
            fetch_addr     = dump_addr_reg + 1'b1;
            dump_addr_next = dump_addr_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign err_set  = (cwr && !wr_in) || (crd && !rd_in) ||
                    (state_reg == IDLE && dump_start && !dump_sel_ok);
  assign err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      dump_sel_reg  <= '0;
      dump_addr_reg <= '0;
      err_reg       <= 1'b0;
      rd_src_reg    <= '0;
      dump_src_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      dump_sel_reg  <= dump_sel_next;
      dump_addr_reg <= dump_addr_next;
      err_reg       <= err_next;
      if (crd)
        rd_src_reg <= rd_in ? csel : 3'b000;
      if (fetch_en)
        dump_src_reg <= dump_sel_reg;
    end
  end

  always_comb begin
    cdata_rd  = '0;
    dump_data = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (rd_src_reg == 3'(i + 1))
        cdata_rd = conv_word[i];
      if (dump_src_reg == 3'(i + 1))
        dump_data = dump_word[i];
    end
  end

  assign dump_valid = (state_reg == RUN);
  assign dump_done  = (state_reg == DONE);
  assign dump_addr  = dump_addr_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_conv_layer_mem.sv
// tb_conv_layer_mem
// Randomised scoreboard bench for conv_layer_mem. Stimulus tasks push the expected
// CONV read words and dump words into queues. The expected values come from a plain
// array model of the five banks. A monitor runs on the falling edge. It pops and
// compares whenever the DUT presents a read result or a dump word, and it checks
// the err and dump_done flags on every cycle.
module tb_conv_layer_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cwr = 1'b0, crd = 1'b0, dump_start = 1'b0, dump_ready = 1'b0, err_clr = 1'b0;
  logic [11:0] caddr_wr = '0, caddr_rd = '0;
  logic [19:0] cdata_wr = '0;
  logic [2:0]  csel = '0, dump_sel = '0;
  logic [19:0] cdata_rd, dump_data;
  logic [11:0] dump_addr;
  logic        dump_valid, dump_done, err;

  always #5 clk = ~clk;

  conv_layer_mem dut (
    .clk(clk), .reset(reset),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .dump_start(dump_start), .dump_sel(dump_sel), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done), .err(err), .err_clr(err_clr)
  );

  int n_vec = 0, n_fail = 0;

  // Reference model: one plain array per bank code, indexed by word address.
  logic [19:0] model_mem [1:5][0:4095];
  int          known_sel[$];
  int          known_addr[$];

  logic [19:0] exp_rd_q[$];
  logic [31:0] exp_dump_q[$];   // {addr[11:0], data[19:0]}

  bit          mon_busy = 0, done_due = 0, rd_prev = 0, err_exp = 0;
  int          start_age = 0;
  logic [19:0] last_rd = '0;

  function automatic int depth_of(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  function automatic bit in_range(input logic [2:0] sel, input logic [11:0] addr);
    return int'(addr) < depth_of(sel);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got 0x%0h, expected 0x%0h", $time, name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("[%0t] FAIL %s", $time, name);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset cdata_rd", cdata_rd, 0);
        check("reset dump_valid", dump_valid, 0);
        check("reset dump_done", dump_done, 0);
        check("reset err", err, 0);
        check("reset dump_addr", dump_addr, 0);
        check("reset dump_data", dump_data, 0);
        exp_rd_q.delete();
        exp_dump_q.delete();
        mon_busy = 0; done_due = 0; rd_prev = 0; err_exp = 0; last_rd = '0;
      end else begin
        if (rd_prev) begin
          if (exp_rd_q.size() == 0) fail_now("cdata_rd with empty expectation queue");
          else begin
            last_rd = exp_rd_q.pop_front();
            check("cdata_rd", cdata_rd, last_rd);
          end
        end else begin
          check("cdata_rd hold", cdata_rd, last_rd);
        end
        check("err", err, err_exp);
        check("dump_done", dump_done, done_due);
        done_due = 0;
        if (mon_busy) begin
          start_age++;
          if (start_age == 1) begin
            check("dump_valid latency", dump_valid, 0);
          end else begin
            check("dump_valid", dump_valid, 1);
            if (exp_dump_q.size() == 0) fail_now("dump word with empty expectation queue");
            else begin
              e = exp_dump_q[0];
              check("dump_addr", dump_addr, e[31:20]);
              check("dump_data", dump_data, e[19:0]);
              if (dump_ready) begin
                void'(exp_dump_q.pop_front());
                if (exp_dump_q.size() == 0) begin
                  mon_busy = 0;
                  done_due = 1;
                end
              end
            end
          end
        end else begin
          check("dump_valid idle", dump_valid, 0);
        end
        // Effect of the inputs that the next rising edge will sample.
        if ((cwr && !in_range(csel, caddr_wr)) || (crd && !in_range(csel, caddr_rd)) ||
            (dump_start && !mon_busy && depth_of(dump_sel) == 0))
          err_exp = 1;
        else if (err_clr)
          err_exp = 0;
        if (dump_start && !mon_busy) begin
          if (depth_of(dump_sel) != 0) begin
            mon_busy  = 1;
            start_age = 0;
          end else begin
            done_due = 1;
          end
        end
        rd_prev = crd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv_op(input bit w, input bit r, input logic [2:0] sel,
                         input logic [11:0] wa, input logic [11:0] ra,
                         input logic [19:0] wd, input bit clr);
    cwr = w; crd = r; csel = sel; caddr_wr = wa; caddr_rd = ra; cdata_wr = wd; err_clr = clr;
    if (r) exp_rd_q.push_back(in_range(sel, ra) ? model_mem[sel][ra] : 20'd0);
    if (w && in_range(sel, wa)) begin
      model_mem[sel][wa] = wd;
      known_sel.push_back(int'(sel));
      known_addr.push_back(int'(wa));
    end
    $display("[%0t] conv wr=%0b rd=%0b sel=%0d waddr=0x%03h raddr=0x%03h wdata=0x%05h clr=%0b",
             $time, w, r, sel, wa, ra, wd, clr);
    tick();
    cwr = 0; crd = 0; err_clr = 0;
  endtask

  // mode 0: dump_ready always high, 1: toggling 1010..., 2: random.
  // When stop_at >= 0, reset is asserted while that address is on the dump port.
  task automatic run_dump(input int mode, input int stop_at);
    int d, cyc;
    bit fin;
    d = depth_of(3'd5);
    cyc = 0;
    fin = 0;
    for (int a = 0; a < d; a++) exp_dump_q.push_back({12'(a), model_mem[5][a]});
    $display("[%0t] dump start sel=5 mode=%0d stop_at=%0d", $time, mode, stop_at);
    dump_sel = 3'd5; dump_start = 1; dump_ready = 1'b0;
    tick();
    dump_start = 0;
    dump_sel = 3'd3;   // the DUT must use the latched value
    while (!fin && cyc < 3 * d + 50) begin
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc % 2 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      dump_start = (mode == 1 && cyc == 500);
      if (stop_at >= 0 && dump_valid && dump_addr == 12'(stop_at)) begin
        reset = 1'b1;
        #1;
        check("async dump_valid drop", dump_valid, 0);
        check("no dump_done on reset", dump_done, 0);
        tick();
        tick();
        reset = 1'b0;
        fin = 1;
      end else begin
        tick();
        cyc++;
        if (exp_dump_q.size() == 0 && !mon_busy) fin = 1;
      end
    end
    if (!fin) fail_now("dump did not complete within cycle budget");
    dump_ready = 0;
    dump_start = 0;
    repeat (4) tick();
    $display("[%0t] dump end mode=%0d cycles=%0d", $time, mode, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("[%0t] FAIL global timeout", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k, idx;
    logic [2:0]  s;
    logic [11:0] a;
    logic [19:0] dat;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Directed cases
    conv_op(1, 0, 3'd1, 12'hFFF, 12'h000, 20'h12345, 0);
    conv_op(0, 1, 3'd1, 12'h000, 12'hFFF, 20'h0, 0);
    conv_op(1, 0, 3'd3, 12'd5, 12'd0, 20'h00001, 0);
    conv_op(1, 1, 3'd3, 12'd5, 12'd5, 20'hAAAAA, 0);       // read-first
    conv_op(0, 1, 3'd3, 12'd0, 12'd5, 20'h0, 0);
    conv_op(1, 0, 3'd4, 12'd0, 12'd0, 20'h0BEEF, 0);
    conv_op(1, 0, 3'd4, 12'd1024, 12'd0, 20'h77777, 0);    // out of range, must not alias to 0
    conv_op(0, 1, 3'd4, 12'd0, 12'd0, 20'h0, 0);
    conv_op(0, 0, 3'd0, 12'd0, 12'd0, 20'h0, 1);           // err_clr
    conv_op(0, 1, 3'd6, 12'd0, 12'd5, 20'h0, 0);           // invalid select read
    conv_op(1, 0, 3'd7, 12'd0, 12'd0, 20'h55555, 1);       // set wins over clear
    conv_op(0, 0, 3'd0, 12'd0, 12'd0, 20'h0, 1);
    tick();

    // Fill L2 completely (dumped later) and scatter writes over L0/L1.
    for (int i = 0; i < 2048; i++) conv_op(1, 0, 3'd5, 12'(i), 12'd0, 20'($urandom), 0);
    repeat (300) begin
      s = 3'($urandom_range(1, 4));
      a = 12'($urandom_range(0, depth_of(s) - 1));
      conv_op(1, 0, s, a, 12'd0, 20'($urandom), 0);
    end

    // Random mix of reads, writes, invalid accesses, read-first collisions and clears
    repeat (400) begin
      k = int'($urandom_range(0, 9));
      dat = 20'($urandom);
      idx = int'($urandom_range(0, known_sel.size() - 1));
      case (k)
        0, 1, 2, 3: begin
          s = 3'($urandom_range(1, 5));
          a = 12'($urandom_range(0, depth_of(s) - 1));
          conv_op(1, 0, s, a, 12'd0, dat, 0);
        end
        4, 5, 6: conv_op(0, 1, 3'(known_sel[idx]), 12'd0, 12'(known_addr[idx]), 20'h0, 0);
        7: begin
          case ($urandom_range(0, 3))
            0:       s = 3'd0;
            1:       s = 3'd6;
            2:       s = 3'd7;
            default: s = 3'($urandom_range(3, 5));
          endcase
          a = (depth_of(s) != 0) ? 12'($urandom_range(depth_of(s), 4095)) : 12'($urandom);
          if ($urandom_range(0, 1) == 1) conv_op(1, 0, s, a, 12'd0, dat, 0);
          else                           conv_op(0, 1, s, 12'd0, a, 20'h0, 0);
        end
        8: conv_op(1, 1, 3'(known_sel[idx]), 12'(known_addr[idx]), 12'(known_addr[idx]), dat, 0);
        default: conv_op(0, 0, 3'd0, 12'd0, 12'd0, 20'h0, 1);
      endcase
    end
    conv_op(0, 0, 3'd0, 12'd0, 12'd0, 20'h0, 1);
    repeat (2) tick();

    // Dumps
    run_dump(0, -1);
    run_dump(1, -1);

    // An invalid dump select goes straight to DONE and raises err.
    $display("[%0t] dump start sel=6 (invalid)", $time);
    dump_sel = 3'd6; dump_start = 1;
    tick();
    dump_start = 0;
    repeat (3) tick();
    conv_op(0, 0, 3'd0, 12'd0, 12'd0, 20'h0, 1);
    tick();

    // Reset in the middle of a dump. Memory contents must survive it.
    run_dump(2, 100);
    conv_op(0, 1, 3'd1, 12'd0, 12'hFFF, 20'h0, 0);
    repeat (20) begin
      idx = int'($urandom_range(0, known_sel.size() - 1));
      conv_op(0, 1, 3'(known_sel[idx]), 12'd0, 12'(known_addr[idx]), 20'h0, 0);
    end
    run_dump(0, -1);

    repeat (3) tick();
    check("read queue drained", exp_rd_q.size(), 0);
    check("dump queue drained", exp_dump_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
